// File: rtl/memory_responder_pkg.sv
// Shared sizing defaults and FSM encoding for the memory responder.
// The defaults must match the CPU data and address widths.
package memory_responder_pkg;

  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_MEM_ADDR_SIZE = 16;
  localparam int DEF_MEM_DEPTH     = 256;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/memory_responder_mem_array.sv
// Word-wide storage array with one synchronous write port and two
// asynchronous read ports (CPU and host).
module memory_responder_mem_array #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [WIDTH-1:0] o_rdata_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; clearing it is the job of the zero-fill sweep.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/memory_responder.sv
// CPU-facing word memory with a host load/dump port, zero-fill sweep after
// reset or on request, and a sticky out-of-range fault flag.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int MEM_DEPTH     = DEF_MEM_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MEM_ADDR_SIZE-1:0] mem_address,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     mem_write_data,
  output logic [WORD_SIZE-1:0]     mem_read_data,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     host_write,
  input  logic [MEM_ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0]     host_wdata,
  output logic [WORD_SIZE-1:0]     host_rdata,
  output logic                     host_rvalid,
  input  logic                     clear,
  output logic                     busy,
  output logic                     fault,
  input  logic                     fault_clear
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [MEM_ADDR_SIZE:0] DEPTH_LIM = (MEM_ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [AW-1:0]          LAST_ADDR = AW'(MEM_DEPTH - 1);

  state_e               r_state;
  logic [AW-1:0]        r_sweep_addr;
  logic [WORD_SIZE-1:0] r_host_rdata;
  logic                 r_host_rvalid;
  logic                 r_fault;

  logic                 w_idle;
  logic                 w_cpu_in_range;
  logic                 w_host_in_range;
  logic                 w_cpu_rd_ok;
  logic                 w_cpu_wr_ok;
  logic                 w_host_ready;
  logic                 w_host_fire;
  logic                 w_host_wr_ok;
  logic                 w_host_rd;
  logic                 w_fault_set;
  logic                 w_we;
  logic [AW-1:0]        w_waddr;
  logic [WORD_SIZE-1:0] w_wdata;
  logic [WORD_SIZE-1:0] w_rdata_cpu;
  logic [WORD_SIZE-1:0] w_rdata_host;

  assign w_idle          = (r_state == IDLE);
  assign w_cpu_in_range  = ({1'b0, mem_address} < DEPTH_LIM);
  assign w_host_in_range = ({1'b0, host_addr} < DEPTH_LIM);

  assign w_cpu_rd_ok  = w_idle && mem_read && w_cpu_in_range;
  assign w_cpu_wr_ok  = w_idle && mem_write && w_cpu_in_range;

  // The CPU always wins: the host is only served when the CPU is quiet.
  assign w_host_ready = w_idle && !mem_read && !mem_write;
  assign w_host_fire  = host_valid && w_host_ready;
  assign w_host_wr_ok = w_host_fire && host_write && w_host_in_range;
  assign w_host_rd    = w_host_fire && !host_write;

  assign w_fault_set  = ((mem_read || mem_write) && !w_cpu_in_range) ||
                        (w_host_fire && !w_host_in_range);

  // NOTE: every output gets a default first so the mux cannot infer a latch.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_sweep_addr;
    w_wdata = '0;
    if (!w_idle) begin
      w_we = 1'b1;
    end else if (w_cpu_wr_ok) begin
      w_we    = 1'b1;
      w_waddr = mem_address[AW-1:0];
      w_wdata = mem_write_data;
    end else if (w_host_wr_ok) begin
      w_we    = 1'b1;
      w_waddr = host_addr[AW-1:0];
      w_wdata = host_wdata;
    end
  end

  memory_responder_mem_array #(
    .WIDTH (WORD_SIZE),
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .i_clk     (clock),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (mem_address[AW-1:0]),
    .o_rdata_a (w_rdata_cpu),
    .i_raddr_b (host_addr[AW-1:0]),
    .o_rdata_b (w_rdata_host)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= SWEEP;
      r_sweep_addr  <= '0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_host_rvalid <= w_host_rd;
      if (w_host_rd) r_host_rdata <= w_host_in_range ? w_rdata_host : '0;

      // A new fault outranks a simultaneous clear request.
      if (w_fault_set)      r_fault <= 1'b1;
      else if (fault_clear) r_fault <= 1'b0;

      case (r_state)
        SWEEP: begin
          if (r_sweep_addr == LAST_ADDR) begin
            r_state      <= IDLE;
            r_sweep_addr <= '0;
          end else begin
            r_sweep_addr <= r_sweep_addr + 1'b1;
          end
        end
        IDLE: begin
          if (clear) begin
            r_state      <= SWEEP;
            r_sweep_addr <= '0;
          end
        end
        default: r_state <= SWEEP;
      endcase
    end
  end

  assign mem_read_data = w_cpu_rd_ok ? w_rdata_cpu : '0;
  assign host_ready    = w_host_ready;
  assign host_rdata    = r_host_rdata;
  assign host_rvalid   = r_host_rvalid;
  assign busy          = !w_idle;
  assign fault         = r_fault;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: sweep timing, CPU/host access paths,
// priority, out-of-range faulting and clear/reset restarts.
module tb_memory_responder;

  logic        clock;
  logic        reset;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        host_valid;
  logic        host_ready;
  logic        host_write;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        clear;
  logic        busy;
  logic        fault;
  logic        fault_clear;

  int checks = 0;
  int errors = 0;
  int cnt;

  memory_responder dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_write     (host_write),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rdata     (host_rdata),
    .host_rvalid    (host_rvalid),
    .clear          (clear),
    .busy           (busy),
    .fault          (fault),
    .fault_clear    (fault_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until busy drops (bounded); optionally pulses clear
  // for one cycle after edge number pulse_at.
  task automatic wait_sweep(input int pulse_at, output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      clear = (n == pulse_at);
    end while (busy && n < 1000);
    clear = 1'b0;
  endtask

  task automatic host_wr(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clock);
    host_valid = 1'b1; host_write = 1'b1; host_addr = addr; host_wdata = data;
    @(negedge clock);
    host_valid = 1'b0; host_write = 1'b0;
  endtask

  task automatic host_rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    @(negedge clock);
    host_valid = 1'b1; host_write = 1'b0; host_addr = addr;
    #1 check({tag, "_ready"}, host_ready, 1);
    @(negedge clock);
    host_valid = 1'b0;
    check({tag, "_rvalid"}, host_rvalid, 1);
    check({tag, "_rdata"}, host_rdata, exp);
    @(negedge clock);
    check({tag, "_rvalid_drop"}, host_rvalid, 0);
  endtask

  task automatic cpu_rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    @(negedge clock);
    mem_read = 1'b1; mem_address = addr;
    #1 check(tag, mem_read_data, exp);
    #1 mem_read = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clock);
    mem_write = 1'b1; mem_address = addr; mem_write_data = data;
    @(negedge clock);
    mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_write_data = '0; host_valid = 1'b0; host_write = 1'b0; host_addr = '0;
    host_wdata = '0; clear = 1'b0; fault_clear = 1'b0;

    // Reset state
    #2;
    check("rst_busy", busy, 1);
    check("rst_rvalid", host_rvalid, 0);
    check("rst_rdata", host_rdata, 0);
    check("rst_fault", fault, 0);
    check("rst_ready", host_ready, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_sweep(-1, cnt);
    check("sweep_len", cnt, 256);

    host_rd(16'd0,   16'h0000, "rd0");
    host_rd(16'd17,  16'h0000, "rd17");
    host_rd(16'd255, 16'h0000, "rd255");

    // Host preload then same-cycle CPU read with host_ready masked
    host_wr(16'd5, 16'h1234);
    @(negedge clock);
    mem_read = 1'b1; mem_address = 16'd5;
    #1;
    check("cpu_rd5", mem_read_data, 16'h1234);
    check("ready_masked", host_ready, 0);
    mem_read = 1'b0;
    #1 check("rd_strobe_low", mem_read_data, 16'h0000);

    // CPU write then host dump; simultaneous read/write returns old word
    cpu_wr(16'd200, 16'hBEEF);
    host_rd(16'd200, 16'hBEEF, "dump200");
    @(negedge clock);
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 16'd200; mem_write_data = 16'h0001;
    #1 check("rw_old", mem_read_data, 16'hBEEF);
    @(negedge clock);
    mem_write = 1'b0;
    #1 check("rw_new", mem_read_data, 16'h0001);
    mem_read = 1'b0;
    check("no_fault_yet", fault, 0);

    // Out-of-range CPU write
    cpu_wr(16'h0100, 16'hFFFF);
    check("oor_fault", fault, 1);
    cpu_rd(16'd0,    16'h0000, "oor_alias0");
    cpu_rd(16'd5,    16'h1234, "oor_keep5");
    cpu_rd(16'd200,  16'h0001, "oor_keep200");
    cpu_rd(16'h0100, 16'h0000, "oor_rd");
    @(negedge clock);
    fault_clear = 1'b1;
    @(negedge clock);
    fault_clear = 1'b0;
    check("fault_cleared", fault, 0);

    // Fault set wins over simultaneous clear; OOR host read gives 0 with rvalid
    @(negedge clock);
    host_valid = 1'b1; host_write = 1'b0; host_addr = 16'h0300; fault_clear = 1'b1;
    @(negedge clock);
    host_valid = 1'b0; fault_clear = 1'b0;
    check("oor_h_rvalid", host_rvalid, 1);
    check("oor_h_rdata", host_rdata, 16'h0000);
    check("set_wins", fault, 1);
    @(negedge clock);
    check("oor_h_rvalid_drop", host_rvalid, 0);
    check("rdata_hold", host_rdata, 16'h0000);

    // Clear mid-operation
    host_wr(16'd10, 16'hAAAA);
    cpu_rd(16'd10, 16'hAAAA, "pre_clear10");
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear_busy", busy, 1);
    mem_read = 1'b1; mem_address = 16'd200;
    #1 check("busy_rd_zero", mem_read_data, 16'h0000);
    check("busy_not_ready", host_ready, 0);
    mem_read = 1'b0;
    repeat (48) @(negedge clock);
    mem_write = 1'b1; mem_address = 16'd3; mem_write_data = 16'h7777;
    @(negedge clock);
    mem_write = 1'b0;
    wait_sweep(-1, cnt);
    check("clear_done", busy, 0);
    cpu_rd(16'd10,  16'h0000, "post_clear10");
    cpu_rd(16'd3,   16'h0000, "busy_wr_dropped");
    cpu_rd(16'd200, 16'h0000, "post_clear200");

    // Reset mid-sweep restarts full sweep; clear during sweep ignored
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (99) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 1);
    check("midrst_fault", fault, 0);
    @(negedge clock);
    reset = 1'b1;
    wait_sweep(50, cnt);
    check("restart_len", cnt, 256);

    // Host backpressure: write held while CPU read toggles
    @(negedge clock);
    host_valid = 1'b1; host_write = 1'b1; host_addr = 16'd3; host_wdata = 16'h5555;
    mem_read = 1'b1; mem_address = 16'd3;
    #1;
    check("bp_ready_lo", host_ready, 0);
    check("bp_rd_before", mem_read_data, 16'h0000);
    @(negedge clock);
    check("bp_not_written", mem_read_data, 16'h0000);
    mem_read = 1'b0;
    #1 check("bp_ready_hi", host_ready, 1);
    @(negedge clock);
    host_valid = 1'b0; host_write = 1'b0;
    mem_read = 1'b1;
    #1 check("bp_written", mem_read_data, 16'h5555);
    @(negedge clock);
    mem_read = 1'b0;
    check("bp_no_fault", fault, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
